interrupt_source_controller: RTL and testbench
==============================================

# interrupt_source_controller

Interrupt initiator for the BWZZ pipelined core. Latches rising edges from up to `NUM_SOURCES` external request lines and applies a software mask. Selects the highest-priority pending source and drives the core's single `interrupt` pin for a fixed number of cycles. Raises nothing further until the core acknowledges completion of the service routine (RTI retired) or an acknowledge timeout expires. Sits between the board-level request lines and the core's `interrupt` input.

## Interface
- `NUM_SOURCES`, 4: number of request lines; index 0 has highest priority.
- `ID_W`, 2: width of `int_id`; must satisfy 2^ID_W >= NUM_SOURCES.
- `PULSE_CYCLES`, 1: cycles `interrupt` is held high per request; legal range >= 1.
- `ACK_TIMEOUT`, 256: cycles to wait in WAIT_ACK before abandoning; 0 disables the timeout.
- `TO_W`, 9: timeout counter width; must satisfy 2^TO_W > ACK_TIMEOUT.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `irq_src`  in  NUM_SOURCES  level request lines, synchronous to `clk`, rising-edge sensitive.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_wdata`  in  NUM_SOURCES  new mask value; bit=1 masks that source.
- `int_ack`  in  1  one-cycle pulse from the core when the interrupt routine's RTI retires.
- `interrupt`  out  1  drives the core's interrupt pin.
- `int_id`  out  ID_W  index of the source being serviced; held stable from RAISE entry until IDLE.
- `pending`  out  NUM_SOURCES  latched, not-yet-serviced requests.
- `busy`  out  1  high in any state other than IDLE.
- `timeout_err`  out  1  sticky; set when an acknowledge timeout occurs.

## Operation
- Edge detect: `prev` register samples `irq_src` each cycle. `edge = irq_src & ~prev`. Each edge bit sets its `pending` bit.
- Masking: masked sources still latch into `pending` but are not eligible. `eligible = pending & ~mask`. Unmasking a pending source makes it eligible on the next cycle.
- Priority: the lowest set index of `eligible` wins.
- FSM states:
  - IDLE: if `eligible != 0`, capture the winner into `int_id`, clear its `pending` bit, and go to RAISE.
  - RAISE: `interrupt=1`; the pulse counter counts to PULSE_CYCLES, then the FSM goes to WAIT_ACK.
  - WAIT_ACK: `interrupt=0`. On `int_ack`, go to COOLDOWN. If ACK_TIMEOUT != 0 and the wait counter reaches ACK_TIMEOUT, set `timeout_err` and go to COOLDOWN.
  - COOLDOWN: one cycle, then go to IDLE. This guarantees at least one low cycle between interrupts, because the core needs a low interrupt input to re-arm its handler.
- `int_ack` outside WAIT_ACK is ignored.
- Set and clear of the same `pending` bit in one cycle: set wins, so a new request is never lost.
- `mask_we` takes effect at the edge where it is sampled. It never aborts a request that has already been captured.
- Reset (reset=0 sampled at an edge), applied to every state including mid-operation:
  - state goes to IDLE;
  - `interrupt`, `pending`, `prev`, `int_id`, `busy`, `timeout_err` and the counters go to 0;
  - mask goes to 0 (all sources enabled).
  - A source already high when reset releases produces no edge; `prev` is loaded from `irq_src` while in reset.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `irq_src[i]` rises and is sampled at edge k:
  - `pending[i]=1` after edge k;
  - `interrupt=1`, `busy=1` and `int_id=i` after edge k+1, when `pending[i]` clears;
  - `interrupt` stays high for exactly PULSE_CYCLES cycles.
- With default parameters, `int_ack` sampled at edge m in WAIT_ACK gives COOLDOWN after m and IDLE with `busy=0` after m+1. The earliest next `interrupt=1` is after m+2.
- Timeout: `timeout_err=1` after the edge at which the wait counter equals ACK_TIMEOUT; `int_id` is held until IDLE.

## Test plan
- Single request: reset, then `irq_src=4'b0100` held. Required: `pending=0100` one cycle later, then `interrupt=1` for 1 cycle with `int_id=2` and `pending=0000`. `int_ack` 5 cycles later gives `busy=0` two cycles after the ack. Holding the level produces no second interrupt.
- Priority and queuing: edges on sources 3 and 1 in the same cycle. Required: source 1 is serviced first (`pending=1000` remains), and after its ack source 3 is raised at m+2 with `int_id=3`.
- Masking: set mask `0001`, then pulse `irq_src[0]`. Required: `pending=0001` and no interrupt. Writing mask `0000` raises the interrupt with `int_id=0` two edges after the write.
- Request during service: a new edge on source 0 while in WAIT_ACK for source 2. Required: `pending[0]=1` and no interrupt until after ack plus cooldown.
- Timeout: with ACK_TIMEOUT=8, withhold `int_ack`. Required: `timeout_err=1` 8 cycles after WAIT_ACK entry, and the FSM returns to IDLE. A stray `int_ack` in IDLE has no effect.
- Reset mid-operation: assert reset while `interrupt=1` and `pending=1010`. Required: after that edge all outputs are 0. `irq_src` held high across reset produces no interrupt after release.

Source files
------------

// File: rtl/interrupt_source_controller.sv
// Interrupt initiator: latches source edges, masks, prioritises and
// drives the core's interrupt pin until the routine's RTI is acknowledged.
module interrupt_source_controller #(
    parameter int NUM_SOURCES  = 4,
    parameter int ID_W         = 2,
    parameter int PULSE_CYCLES = 1,
    parameter int ACK_TIMEOUT  = 256,
    parameter int TO_W         = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq_src,
    input  logic                   mask_we,
    input  logic [NUM_SOURCES-1:0] mask_wdata,
    input  logic                   int_ack,
    output logic                   interrupt,
    output logic [ID_W-1:0]        int_id,
    output logic [NUM_SOURCES-1:0] pending,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RAISE,
        WAIT_ACK,
        COOLDOWN
    } state_t;

    state_t state;
    state_t nextState;

    logic [NUM_SOURCES-1:0] prevSrc;
    logic [NUM_SOURCES-1:0] maskReg;
    logic [NUM_SOURCES-1:0] srcEdge;
    logic [NUM_SOURCES-1:0] eligible;
    logic [NUM_SOURCES-1:0] pendClr;
    logic [ID_W-1:0]        winner;
    logic                   anyEligible;
    logic [PCW-1:0]         pulseCnt;
    logic [TO_W-1:0]        waitCnt;
    logic                   pulseDone;
    logic                   waitExpired;
    logic                   toFire;

    always_comb begin
        srcEdge     = irq_src & ~prevSrc;
        eligible    = pending & ~maskReg;
        winner      = '0;
        anyEligible = 1'b0;
        // Scan downwards so the lowest set index is the one left standing.
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner      = ID_W'(i);
                anyEligible = 1'b1;
            end
        end
    end

    assign pulseDone   = (pulseCnt == PCW'(PULSE_CYCLES - 1));
    assign waitExpired = (ACK_TIMEOUT != 0) &&
                         (waitCnt == TO_W'(ACK_TIMEOUT - 1));

    always_comb begin
        nextState = state;
        pendClr   = '0;
        toFire    = 1'b0;
        unique case (state)
            IDLE: begin
                if (anyEligible) begin
                    nextState = RAISE;
                    pendClr   = eligible & (~eligible + 1'b1);
                end
            end
            RAISE: begin
                if (pulseDone) begin
                    nextState = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (int_ack) begin
                    nextState = COOLDOWN;
                end else if (waitExpired) begin
                    nextState = COOLDOWN;
                    toFire    = 1'b1;
                end
            end
            COOLDOWN: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            prevSrc     <= irq_src;
            pending     <= '0;
            maskReg     <= '0;
            int_id      <= '0;
            interrupt   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            pulseCnt    <= '0;
            waitCnt     <= '0;
        end else begin
            state     <= nextState;
            prevSrc   <= irq_src;
            pending   <= (pending & ~pendClr) | srcEdge;
            interrupt <= (nextState == RAISE);
            busy      <= (nextState != IDLE);
            if (mask_we) begin
                maskReg <= mask_wdata;
            end
            if (state == IDLE && anyEligible) begin
                int_id <= winner;
            end
            if (toFire) begin
                timeout_err <= 1'b1;
            end
            pulseCnt <= (state == RAISE) ? pulseCnt + 1'b1 : '0;
            waitCnt  <= (state == WAIT_ACK) ? waitCnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_interrupt_source_controller.sv
// Randomised and directed bench for interrupt_source_controller
// with a reference model feeding an expected-output scoreboard.
module tb_interrupt_source_controller;

    localparam int NS  = 4;
    localparam int PC  = 1;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [NS-1:0] irq_src;
    logic          mask_we;
    logic [NS-1:0] mask_wdata;
    logic          int_ack;
    logic          interrupt;
    logic [1:0]    int_id;
    logic [NS-1:0] pending;
    logic          busy;
    logic          timeout_err;

    interrupt_source_controller #(
        .NUM_SOURCES (NS),
        .ID_W        (2),
        .PULSE_CYCLES(PC),
        .ACK_TIMEOUT (TMO),
        .TO_W        (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .interrupt  (interrupt),
        .int_id     (int_id),
        .pending    (pending),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          intr;
        logic [1:0]    id;
        logic [NS-1:0] pend;
        logic          bsy;
        logic          terr;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFail   = 0;

    // Reference model: phase 0 idle, 1 pulsing, 2 awaiting ack, 3 gap.
    int            phase;
    int            pulseLeft;
    int            waited;
    logic [NS-1:0] mPend;
    logic [NS-1:0] mMask;
    logic [NS-1:0] mPrev;
    logic [1:0]    mId;
    logic          mTerr;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got %0h required %0h at %0t",
                     nm, act, req, $time);
        end
    endtask

    task automatic modelStep(input logic r, input logic [NS-1:0] s,
                             input logic we, input logic [NS-1:0] wd,
                             input logic a);
        logic [NS-1:0] edges;
        logic [NS-1:0] elig;
        logic [NS-1:0] clr;
        bit            found;
        exp_t          e;
        if (!r) begin
            phase = 0;
            pulseLeft = 0;
            waited = 0;
            mPend = '0;
            mMask = '0;
            mId = '0;
            mTerr = 1'b0;
            mPrev = s;
        end else begin
            edges = s & ~mPrev;
            clr = '0;
            case (phase)
                0: begin
                    elig = mPend & ~mMask;
                    found = 0;
                    for (int i = 0; i < NS; i++) begin
                        if (!found && elig[i]) begin
                            found = 1;
                            mId = 2'(i);
                            clr[i] = 1'b1;
                        end
                    end
                    if (found) begin
                        phase = 1;
                        pulseLeft = PC;
                    end
                end
                1: begin
                    pulseLeft--;
                    if (pulseLeft == 0) begin
                        phase = 2;
                        waited = 0;
                    end
                end
                2: begin
                    waited++;
                    if (a) begin
                        phase = 3;
                    end else if (waited == TMO) begin
                        mTerr = 1'b1;
                        phase = 3;
                    end
                end
                default: phase = 0;
            endcase
            mPend = (mPend & ~clr) | edges;
            if (we) mMask = wd;
            mPrev = s;
        end
        e.intr = (phase == 1);
        e.id   = mId;
        e.pend = mPend;
        e.bsy  = (phase != 0);
        e.terr = mTerr;
        expQ.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic [NS-1:0] s,
                       input logic we = 1'b0,
                       input logic [NS-1:0] wd = '0,
                       input logic a = 1'b0);
        reset = r;
        irq_src = s;
        mask_we = we;
        mask_wdata = wd;
        int_ack = a;
        @(posedge clk);
        modelStep(r, s, we, wd, a);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk("interrupt", 32'(interrupt), 32'(e.intr));
            chk("int_id", 32'(int_id), 32'(e.id));
            chk("pending", 32'(pending), 32'(e.pend));
            chk("busy", 32'(busy), 32'(e.bsy));
            chk("timeout_err", 32'(timeout_err), 32'(e.terr));
        end
    end

    initial begin
        logic [NS-1:0] s;
        reset = 1'b0;
        irq_src = '0;
        mask_we = 1'b0;
        mask_wdata = '0;
        int_ack = 1'b0;
        mPrev = '0;
        @(negedge clk);
        repeat (3) cyc(1'b0, 4'b0000);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single request held high
        cyc(1'b1, 4'b0100);
        chk("single_pend", 32'(pending), 32'h4);
        chk("single_noint", 32'(interrupt), 32'd0);
        cyc(1'b1, 4'b0100);
        chk("single_int", 32'(interrupt), 32'd1);
        chk("single_id", 32'(int_id), 32'd2);
        chk("single_clr", 32'(pending), 32'd0);
        repeat (4) cyc(1'b1, 4'b0100);
        cyc(1'b1, 4'b0100, 1'b0, '0, 1'b1);
        chk("ack_cool", 32'(busy), 32'd1);
        cyc(1'b1, 4'b0100);
        chk("ack_idle", 32'(busy), 32'd0);
        repeat (5) cyc(1'b1, 4'b0100);

        // Priority and queuing
        repeat (2) cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b1010);
        repeat (3) cyc(1'b1, 4'b1010);
        cyc(1'b1, 4'b0000, 1'b0, '0, 1'b1);
        repeat (5) cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0000, 1'b0, '0, 1'b1);
        repeat (3) cyc(1'b1, 4'b0000);

        // Masking
        cyc(1'b1, 4'b0000, 1'b1, 4'b0001);
        cyc(1'b1, 4'b0001);
        repeat (3) cyc(1'b1, 4'b0000);
        chk("mask_noint", 32'(busy), 32'd0);
        cyc(1'b1, 4'b0000, 1'b1, 4'b0000);
        repeat (3) cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0000, 1'b0, '0, 1'b1);
        repeat (3) cyc(1'b1, 4'b0000);

        // Request during service
        cyc(1'b1, 4'b0100);
        repeat (3) cyc(1'b1, 4'b0100);
        cyc(1'b1, 4'b0101);
        repeat (3) cyc(1'b1, 4'b0101);
        cyc(1'b1, 4'b0101, 1'b0, '0, 1'b1);
        repeat (4) cyc(1'b1, 4'b0101);
        cyc(1'b1, 4'b0000, 1'b0, '0, 1'b1);
        repeat (3) cyc(1'b1, 4'b0000);

        // Timeout, then stray ack in idle
        cyc(1'b1, 4'b0100);
        repeat (14) cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0000, 1'b0, '0, 1'b1);
        repeat (3) cyc(1'b1, 4'b0000);

        // Reset mid-operation
        cyc(1'b0, 4'b0000);
        cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b1011);
        cyc(1'b1, 4'b1011);
        chk("mid_int", 32'(interrupt), 32'd1);
        chk("mid_pend", 32'(pending), 32'hA);
        cyc(1'b0, 4'b1011);
        chk("rst_int", 32'(interrupt), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        repeat (4) cyc(1'b1, 4'b1011);
        chk("rel_noint", 32'(busy), 32'd0);

        // Randomised traffic
        s = '0;
        for (int n = 0; n < 3000; n++) begin
            s = s ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            cyc(($urandom_range(0, 79) != 0), s,
                ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 5) == 0));
        end
        @(negedge clk);
        chk("queue_drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFail);
        $finish;
    end

endmodule
